freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 18 +
 rtl/freq_meter_edge_sync.sv | 31 +++
 rtl/freq_meter.sv | 106 ++++++++++
 tb/tb_freq_meter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and parameter derivations for the gated frequency meter.
package freq_meter_pkg;

   typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_e;

   localparam int DEF_IN_FREQ_MHZ = 100;
   localparam int DEF_GATE_US     = 10;

   function automatic int gate_cycles(input int in_freq_mhz, input int gate_us);
      return in_freq_mhz * gate_us;
   endfunction

   // Half the gate length is the most edges a signal at clk_in/2 can produce.
   function automatic int count_w(input int in_freq_mhz, input int gate_us);
      return $clog2(gate_cycles(in_freq_mhz, gate_us) / 2 + 1);
   endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector;
// a 0->1 on d_in shows up as a one-cycle rise_pulse three clocks later.
module edge_sync (
   input  logic clk_in,
   input  logic reset,
   input  logic d_in,
   output logic rise_pulse
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic pulse_q;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= d_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         pulse_q <= sync2_q & ~prev_q;
      end
   end

   assign rise_pulse = pulse_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a
// fixed window of clk_in cycles, single-shot or back-to-back.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int IN_FREQ_MHZ = DEF_IN_FREQ_MHZ,
   parameter int GATE_US     = DEF_GATE_US,
   localparam int GATE_CYCLES = gate_cycles(IN_FREQ_MHZ, GATE_US),
   localparam int COUNT_W     = count_w(IN_FREQ_MHZ, GATE_US)
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic               sig_in,
   input  logic               start,
   input  logic               continuous,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] edge_count
);

   localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

   state_e             state_q;
   logic [GATE_W-1:0]  gate_q;
   logic [COUNT_W-1:0] acc_q;
   logic [COUNT_W-1:0] acc_d;
   logic [COUNT_W-1:0] edge_count_q;
   logic               busy_q;
   logic               done_q;
   logic               edge_pulse;
   logic               gate_last;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (&v) ? v : v + COUNT_W'(1);
   endfunction

   edge_sync u_edge_sync (
      .clk_in     (clk_in),
      .reset      (reset),
      .d_in       (sig_in),
      .rise_pulse (edge_pulse)
   );

   assign gate_last = (gate_q == GATE_W'(GATE_CYCLES - 1));

   // Accumulator value including this cycle's edge, so the final gate cycle counts.
   always_comb begin
      acc_d = acc_q;
      if (edge_pulse) begin
         acc_d = sat_inc(acc_q);
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         gate_q       <= '0;
         acc_q        <= '0;
         edge_count_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start || continuous) begin
                  state_q <= MEASURE;
                  gate_q  <= '0;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            MEASURE: begin
               acc_q  <= acc_d;
               gate_q <= gate_q + GATE_W'(1);
               if (gate_last) begin
                  state_q      <= DONE;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  edge_count_q <= acc_d;
               end
            end
            DONE: begin
               // Start is deliberately not looked at here; only continuous re-arms.
               if (continuous) begin
                  state_q <= MEASURE;
                  gate_q  <= '0;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign edge_count = edge_count_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: expected window results are queued when a
// measurement is launched and compared when the done pulse appears.
module tb_freq_meter;

   localparam int IN_FREQ = 100;
   localparam int GATE    = 10;
   localparam int CW      = $clog2(IN_FREQ * GATE / 2 + 1);
   localparam int WIN     = IN_FREQ * GATE;

   logic          clk_in = 1'b0;
   logic          reset;
   logic          sig_in;
   logic          start;
   logic          continuous;
   logic          busy;
   logic          done;
   logic [CW-1:0] edge_count;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int freq_mhz = 0;
   int ph       = 0;

   typedef struct {
      int cnt;
      int tol;
      int at;
   } exp_t;
   exp_t sb[$];

   freq_meter dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .sig_in     (sig_in),
      .start      (start),
      .continuous (continuous),
      .busy       (busy),
      .done       (done),
      .edge_count (edge_count)
   );

   initial forever #5 clk_in = ~clk_in;

   initial forever begin
      @(posedge clk_in);
      cyc++;
   end

   // Phase-accumulator divider: sig_in toggles 2*freq_mhz times per IN_FREQ clocks.
   initial forever begin
      @(negedge clk_in);
      if (freq_mhz != 0) begin
         ph += 2 * freq_mhz;
         if (ph >= IN_FREQ) begin
            ph -= IN_FREQ;
            sig_in = ~sig_in;
         end
      end
   end

   task automatic check(input string tag, input int obs, input int exp, input int tol);
      logic ok;
      checks++;
      ok = (obs >= exp - tol) && (obs <= exp + tol);
      assert (ok === 1'b1) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic wait_until(input int c);
      int t = 0;
      while (cyc < c && t < 5000) begin
         @(negedge clk_in);
         t++;
      end
   endtask

   task automatic pulse_start(output int s);
      @(negedge clk_in);
      start = 1'b1;
      s = cyc;
      @(negedge clk_in);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int   t = 0;
      exp_t e;
      do begin
         @(negedge clk_in);
         t++;
      end while (done !== 1'b1 && t < 3000);
      if (done !== 1'b1) begin
         check({tag, "_timeout"}, int'(done), 1, 0);
         return;
      end
      if (sb.size() == 0) begin
         check({tag, "_unexpected"}, int'(done), 0, 0);
         return;
      end
      e = sb.pop_front();
      check({tag, "_count"}, int'(edge_count), e.cnt, e.tol);
      check({tag, "_cycle"}, cyc, e.at, 0);
      @(negedge clk_in);
      check({tag, "_single"}, int'(done), 0, 0);
   endtask

   task automatic count_dones(input string tag, input int n);
      int seen = 0;
      repeat (n) begin
         @(negedge clk_in);
         if (done === 1'b1) seen++;
      end
      check(tag, seen, 0, 0);
   endtask

   initial begin
      int s;
      int s2;
      reset      = 1'b0;
      start      = 1'b0;
      continuous = 1'b0;
      sig_in     = 1'b0;
      #1;
      check("rst_busy", int'(busy), 0, 0);
      check("rst_done", int'(done), 0, 0);
      check("rst_count", int'(edge_count), 0, 0);
      wait_cyc(3);
      reset = 1'b1;

      // Edges while idle must not start or count anything.
      freq_mhz = 50;
      wait_cyc(50);
      check("idle_busy", int'(busy), 0, 0);
      check("idle_count", int'(edge_count), 0, 0);

      pulse_start(s);
      sb.push_back('{500, 1, s + WIN + 1});
      check("f50_busy", int'(busy), 1, 0);
      wait_done("f50");
      wait_cyc(20);
      check("f50_hold", int'(edge_count), 500, 1);
      check("f50_idle", int'(busy), 0, 0);

      freq_mhz = 10;
      pulse_start(s);
      sb.push_back('{100, 1, s + WIN + 1});
      wait_done("f10");

      freq_mhz = 1;
      pulse_start(s);
      sb.push_back('{10, 1, s + WIN + 1});
      wait_done("f1");

      // A second start mid-window is ignored.
      freq_mhz = 10;
      pulse_start(s);
      sb.push_back('{100, 1, s + WIN + 1});
      wait_until(s + 200);
      pulse_start(s2);
      wait_done("restart");
      count_dones("restart_none", 1100);
      check("restart_idle", int'(busy), 0, 0);

      // Back-to-back windows, then drop continuous mid-window.
      freq_mhz = 30;
      @(negedge clk_in);
      continuous = 1'b1;
      s = cyc;
      for (int k = 1; k <= 3; k++) sb.push_back('{300, 1, s + k * (WIN + 1)});
      wait_done("c1");
      wait_done("c2");
      wait_cyc(10);
      continuous = 1'b0;
      wait_done("c3");
      count_dones("c_stop", 1100);
      check("c_idle", int'(busy), 0, 0);

      // Reset in the middle of a window.
      freq_mhz = 50;
      pulse_start(s);
      wait_until(s + 400);
      reset = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0, 0);
      check("abort_count", int'(edge_count), 0, 0);
      check("abort_done", int'(done), 0, 0);
      wait_cyc(3);
      reset = 1'b1;
      count_dones("abort_none", 1100);
      check("abort_idle", int'(busy), 0, 0);
      pulse_start(s);
      sb.push_back('{500, 1, s + WIN + 1});
      wait_done("after_abort");

      // Constant-high input, then single edges at the final gate cycle and just after.
      freq_mhz = 0;
      sig_in = 1'b1;
      wait_cyc(10);
      pulse_start(s);
      sb.push_back('{0, 0, s + WIN + 1});
      wait_done("const_hi");

      sig_in = 1'b0;
      wait_cyc(10);
      pulse_start(s);
      sb.push_back('{1, 0, s + WIN + 1});
      wait_until(s + WIN - 3);
      sig_in = 1'b1;
      wait_done("last_edge");

      sig_in = 1'b0;
      wait_cyc(10);
      pulse_start(s);
      sb.push_back('{0, 0, s + WIN + 1});
      wait_until(s + WIN - 2);
      sig_in = 1'b1;
      wait_done("late_edge");

      check("sb_empty", sb.size(), 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
